// File: rtl/dsm_mod2_if.sv
// Stream bundle for the second-order delta-sigma modulator: PCM sample
// input with valid/ready, and the 2-bit bitstream output with status.
interface dsm_mod2_if #(
   parameter int IN_W = 16
);
   logic signed [IN_W-1:0] in;
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             out;
   logic                   out_valid;
   logic                   underrun;

   // Producer / bitstream consumer side
   modport master (
      output in, in_valid,
      input  in_ready, out, out_valid, underrun
   );

   // Modulator side
   modport slave (
      input  in, in_valid,
      output in_ready, out, out_valid, underrun
   );
endinterface

// File: rtl/dsm_mod2.sv
// Second-order delta-sigma modulator. Each accepted PCM sample is held for
// OSR clocks (zero-order hold) and a +1/-1 symbol is produced every clock
// once running. Integrators saturate instead of wrapping.
module dsm_mod2 #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 20,
   parameter int OSR   = 64
) (
   input logic       clk,
   input logic       rst,
   dsm_mod2_if.slave bus
);
   localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int EXT_W = ACC_W + 2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

   // Full scale 2^(IN_W-1) and the integrator limits, all at the widened size
   localparam logic signed [EXT_W-1:0] FS_E =
      $signed({{(EXT_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}});
   localparam logic signed [EXT_W-1:0] ACC_MAX_E =
      $signed({{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}});
   localparam logic signed [EXT_W-1:0] ACC_MIN_E =
      $signed({{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}});

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Clamp a widened sum back into the integrator range
   function automatic logic signed [ACC_W-1:0] sat(input logic signed [EXT_W-1:0] v);
      logic signed [ACC_W-1:0] r;
      if (v > ACC_MAX_E) begin
         r = $signed(ACC_MAX_E[ACC_W-1:0]);
      end else if (v < ACC_MIN_E) begin
         r = $signed(ACC_MIN_E[ACC_W-1:0]);
      end else begin
         r = $signed(v[ACC_W-1:0]);
      end
      return r;
   endfunction

   state_t                  state_q, state_d;
   logic signed [IN_W-1:0]  x_hold_q, x_hold_d;
   logic signed [ACC_W-1:0] i1_q, i1_d;
   logic signed [ACC_W-1:0] i2_q, i2_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [1:0]              out_q, out_d;
   logic                    out_valid_q, out_valid_d;
   logic                    underrun_q, underrun_d;

   logic                    in_ready;
   logic                    accept;
   logic                    y_pos;
   logic signed [EXT_W-1:0] v_e;
   logic signed [EXT_W-1:0] x_e;
   logic signed [EXT_W-1:0] i1_e;
   logic signed [EXT_W-1:0] i2_e;
   logic signed [EXT_W-1:0] sum1;
   logic signed [ACC_W-1:0] i1_new;
   logic signed [EXT_W-1:0] i1n_e;
   logic signed [EXT_W-1:0] sum2;
   logic signed [ACC_W-1:0] i2_new;

   assign in_ready = (state_q == IDLE) || (cnt_q == CNT_LAST);
   assign accept   = bus.in_valid && in_ready;

   // Quantiser decision on the sign of the second integrator; feedback is +/-FS
   assign y_pos = ~i2_q[ACC_W-1];
   assign v_e   = y_pos ? FS_E : -FS_E;

   assign x_e  = {{(EXT_W-IN_W){x_hold_q[IN_W-1]}}, x_hold_q};
   assign i1_e = {{(EXT_W-ACC_W){i1_q[ACC_W-1]}}, i1_q};
   assign i2_e = {{(EXT_W-ACC_W){i2_q[ACC_W-1]}}, i2_q};

   // Both integrators halve their input; the second sees the freshly updated i1
   assign sum1   = i1_e + ((x_e - v_e) >>> 1);
   assign i1_new = sat(sum1);
   assign i1n_e  = {{(EXT_W-ACC_W){i1_new[ACC_W-1]}}, i1_new};
   assign sum2   = i2_e + ((i1n_e - v_e) >>> 1);
   assign i2_new = sat(sum2);

   // Next-state: IDLE waits for the first sample, RUN updates every clock
   always_comb begin
      state_d     = state_q;
      x_hold_d    = x_hold_q;
      i1_d        = i1_q;
      i2_d        = i2_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      underrun_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               x_hold_d = bus.in;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            out_d       = y_pos ? 2'b01 : 2'b11;
            out_valid_d = 1'b1;
            i1_d        = i1_new;
            i2_d        = i2_new;
            if (cnt_q == CNT_LAST) begin
               // This update still used the old sample; the new one takes over next clock
               cnt_d = '0;
               if (accept) begin
                  x_hold_d = bus.in;
               end else begin
                  underrun_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         x_hold_q    <= '0;
         i1_q        <= '0;
         i2_q        <= '0;
         cnt_q       <= '0;
         out_q       <= 2'b00;
         out_valid_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_hold_q    <= x_hold_d;
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         underrun_q  <= underrun_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.underrun  = underrun_q;
endmodule

// File: tb/tb_dsm_mod2.sv
// Bench for dsm_mod2: a behavioural modulator model pushes the expected
// result of every clock into a queue, each test pops and compares it, and
// fixed reference values from the known start-up sequence are checked too.
module tb_dsm_mod2;
   localparam int IN_W  = 16;
   localparam int ACC_W = 20;
   localparam int OSR   = 64;
   localparam longint FS    = 32768;
   localparam longint A_MAX = 524287;
   localparam longint A_MIN = -524288;

   logic clk = 1'b0;
   logic rst = 1'b0;

   dsm_mod2_if #(.IN_W(IN_W)) bus ();

   dsm_mod2 #(.IN_W(IN_W), .ACC_W(ACC_W), .OSR(OSR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] out;
      logic       ov;
      logic       ur;
      logic       rdy;
      longint     i1;
      longint     i2;
      longint     x;
   } exp_t;

   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   bit         m_run;
   longint     m_i1, m_i2, m_x;
   int         m_cnt;
   logic [1:0] m_out;
   logic       m_ov;
   logic       m_rdy;

   function automatic longint sat(input longint v);
      if (v > A_MAX) return A_MAX;
      if (v < A_MIN) return A_MIN;
      return v;
   endfunction

   task automatic model_reset();
      m_run = 0; m_i1 = 0; m_i2 = 0; m_x = 0; m_cnt = 0;
      m_out = 2'b00; m_ov = 1'b0; m_rdy = 1'b1;
      exp_q.delete();
   endtask

   // Drive one clock of stimulus, predict its result, advance past the edge
   task automatic drive(input logic v, input int d, output logic acc);
      exp_t   e;
      longint vv, n1;
      bus.in_valid = v;
      bus.in       = 16'(d);
      acc  = v && m_rdy;
      e.ur = 1'b0;
      if (!m_run) begin
         if (acc) begin
            m_x = d; m_cnt = 0; m_run = 1;
         end
      end else begin
         vv    = (m_i2 >= 0) ? FS : -FS;
         m_out = (m_i2 >= 0) ? 2'b01 : 2'b11;
         m_ov  = 1'b1;
         n1    = sat(m_i1 + ((m_x - vv) >>> 1));
         m_i2  = sat(m_i2 + ((n1 - vv) >>> 1));
         m_i1  = n1;
         if (m_cnt == OSR - 1) begin
            m_cnt = 0;
            if (acc) m_x = d;
            else e.ur = 1'b1;
         end else begin
            m_cnt++;
         end
      end
      m_rdy = !m_run || (m_cnt == OSR - 1);
      e.out = m_out; e.ov = m_ov; e.rdy = m_rdy;
      e.i1 = m_i1; e.i2 = m_i2; e.x = m_x;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      bus.in       = '0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.in       = '0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (bus.out !== 2'b00 || bus.out_valid !== 1'b0 || bus.underrun !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs: out=%b ov=%b ur=%b rdy=%b, expected 00 0 0 1",
                  bus.out, bus.out_valid, bus.underrun, bus.in_ready);
      end
      n_tests++;
      if (longint'(dut.i1_q) !== 0 || longint'(dut.i2_q) !== 0 || longint'(dut.x_hold_q) !== 0) begin
         n_fail++;
         $display("FAIL reset_state: i1=%0d i2=%0d x=%0d, expected 0 0 0",
                  dut.i1_q, dut.i2_q, dut.x_hold_q);
      end
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_zero_start();
      exp_t       e;
      logic       acc;
      logic [1:0] sym_ref [4];
      longint     i1_ref  [3];
      sym_ref[0] = 2'b01; sym_ref[1] = 2'b11; sym_ref[2] = 2'b11; sym_ref[3] = 2'b01;
      i1_ref[0] = -16384; i1_ref[1] = 0; i1_ref[2] = 16384;
      do_reset();
      for (int j = 0; j <= 3 * OSR; j++) begin
         drive(j == 0, 0, acc);
         e = exp_q.pop_front();
         n_tests++;
         if (bus.out !== e.out || bus.out_valid !== e.ov || bus.underrun !== e.ur || bus.in_ready !== e.rdy) begin
            n_fail++;
            $display("FAIL zero_stream j=%0d: out=%b ov=%b ur=%b rdy=%b, expected %b %b %b %b",
                     j, bus.out, bus.out_valid, bus.underrun, bus.in_ready, e.out, e.ov, e.ur, e.rdy);
         end
         n_tests++;
         if (longint'(dut.i1_q) !== e.i1 || longint'(dut.i2_q) !== e.i2) begin
            n_fail++;
            $display("FAIL zero_integ j=%0d: i1=%0d i2=%0d, expected %0d %0d", j, dut.i1_q, dut.i2_q, e.i1, e.i2);
         end
         n_tests++;
         if (bus.out_valid !== (j >= 1)) begin
            n_fail++;
            $display("FAIL zero_latency j=%0d: out_valid=%b, expected %b", j, bus.out_valid, (j >= 1));
         end
         if (j >= 1 && j <= 4) begin
            n_tests++;
            if (bus.out !== sym_ref[j-1]) begin
               n_fail++;
               $display("FAIL zero_symbol j=%0d: out=%b, expected %b", j, bus.out, sym_ref[j-1]);
            end
         end
         if (j >= 1 && j <= 3) begin
            n_tests++;
            if (longint'(dut.i1_q) !== i1_ref[j-1]) begin
               n_fail++;
               $display("FAIL zero_i1 j=%0d: i1=%0d, expected %0d", j, dut.i1_q, i1_ref[j-1]);
            end
         end
         n_tests++;
         if (bus.underrun !== (j >= 1 && (j % OSR) == 0)) begin
            n_fail++;
            $display("FAIL zero_underrun j=%0d: underrun=%b, expected %b", j, bus.underrun, (j >= 1 && (j % OSR) == 0));
         end
      end
   endtask

   task automatic test_dc(input int level, input int nsym, input int lo_pos, input int hi_pos, input string name);
      exp_t e;
      logic acc;
      int   npos;
      npos = 0;
      do_reset();
      drive(1'b1, level, acc);
      void'(exp_q.pop_front());
      for (int j = 0; j < nsym; j++) begin
         drive(1'b1, level, acc);
         e = exp_q.pop_front();
         if (bus.out === 2'b01) npos++;
         n_tests++;
         if (bus.out !== e.out || bus.out_valid !== e.ov || bus.underrun !== e.ur ||
             longint'(dut.i1_q) !== e.i1 || longint'(dut.i2_q) !== e.i2) begin
            n_fail++;
            $display("FAIL %s_stream j=%0d: out=%b ov=%b ur=%b i1=%0d i2=%0d, expected %b %b %b %0d %0d",
                     name, j, bus.out, bus.out_valid, bus.underrun, dut.i1_q, dut.i2_q,
                     e.out, e.ov, e.ur, e.i1, e.i2);
         end
      end
      n_tests++;
      if (npos < lo_pos || npos > hi_pos) begin
         n_fail++;
         $display("FAIL %s_density: +1 count=%0d of %0d, expected %0d..%0d", name, npos, nsym, lo_pos, hi_pos);
      end
   endtask

   task automatic test_handshake();
      exp_t e;
      logic acc;
      int   next, nrdy, nur;
      next = 0; nrdy = 0; nur = 0;
      do_reset();
      drive(1'b1, next, acc);
      if (acc) next++;
      void'(exp_q.pop_front());
      for (int j = 1; j <= 10 * OSR; j++) begin
         if (bus.in_ready === 1'b1) nrdy++;
         drive(1'b1, next, acc);
         if (acc) next++;
         e = exp_q.pop_front();
         if (bus.underrun === 1'b1) nur++;
         n_tests++;
         if (bus.out !== e.out || bus.in_ready !== e.rdy || longint'(dut.x_hold_q) !== e.x) begin
            n_fail++;
            $display("FAIL hs_stream j=%0d: out=%b rdy=%b x=%0d, expected %b %b %0d",
                     j, bus.out, bus.in_ready, dut.x_hold_q, e.out, e.rdy, e.x);
         end
      end
      n_tests++;
      if (nrdy != 10) begin
         n_fail++;
         $display("FAIL hs_ready_count: %0d ready cycles, expected 10", nrdy);
      end
      n_tests++;
      if (next != 11) begin
         n_fail++;
         $display("FAIL hs_accepted: %0d samples, expected 11", next);
      end
      n_tests++;
      if (nur != 0) begin
         n_fail++;
         $display("FAIL hs_underrun: %0d pulses, expected 0", nur);
      end
      n_tests++;
      if (longint'(dut.x_hold_q) !== 10) begin
         n_fail++;
         $display("FAIL hs_last_sample: x_hold=%0d, expected 10", dut.x_hold_q);
      end
   endtask

   task automatic test_underrun();
      exp_t e;
      logic acc;
      int   nacc, nur, nov;
      nacc = 0; nur = 0; nov = 0;
      do_reset();
      for (int j = 0; j <= 6 * OSR; j++) begin
         drive(nacc < 3, (nacc + 1) * 100, acc);
         if (acc) nacc++;
         e = exp_q.pop_front();
         if (bus.underrun === 1'b1) nur++;
         if (j >= 1 && bus.out_valid !== 1'b1) nov++;
         n_tests++;
         if (bus.out !== e.out || bus.underrun !== e.ur || longint'(dut.i1_q) !== e.i1 || longint'(dut.x_hold_q) !== e.x) begin
            n_fail++;
            $display("FAIL ur_stream j=%0d: out=%b ur=%b i1=%0d x=%0d, expected %b %b %0d %0d",
                     j, bus.out, bus.underrun, dut.i1_q, dut.x_hold_q, e.out, e.ur, e.i1, e.x);
         end
      end
      n_tests++;
      if (nur != 4) begin
         n_fail++;
         $display("FAIL ur_pulses: %0d, expected 4", nur);
      end
      n_tests++;
      if (nov != 0) begin
         n_fail++;
         $display("FAIL ur_out_valid: %0d cycles without out_valid, expected 0", nov);
      end
      n_tests++;
      if (longint'(dut.x_hold_q) !== 300) begin
         n_fail++;
         $display("FAIL ur_hold: x_hold=%0d, expected 300", dut.x_hold_q);
      end
   endtask

   task automatic test_async_reset();
      exp_t       e;
      logic       acc;
      logic [1:0] sym_ref [3];
      sym_ref[0] = 2'b01; sym_ref[1] = 2'b11; sym_ref[2] = 2'b11;
      do_reset();
      for (int j = 0; j < 30; j++) begin
         drive(j == 0, 0, acc);
         e = exp_q.pop_front();
         n_tests++;
         if (bus.out !== e.out || bus.out_valid !== e.ov) begin
            n_fail++;
            $display("FAIL ar_pre j=%0d: out=%b ov=%b, expected %b %b", j, bus.out, bus.out_valid, e.out, e.ov);
         end
      end
      #3;
      rst = 1'b0;
      #1;
      n_tests++;
      if (bus.out !== 2'b00 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || longint'(dut.i1_q) !== 0) begin
         n_fail++;
         $display("FAIL ar_immediate: out=%b ov=%b rdy=%b i1=%0d, expected 00 0 1 0",
                  bus.out, bus.out_valid, bus.in_ready, dut.i1_q);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int j = 0; j <= 3; j++) begin
         drive(j == 0, 0, acc);
         e = exp_q.pop_front();
         n_tests++;
         if (bus.out !== e.out || bus.out_valid !== e.ov || longint'(dut.i1_q) !== e.i1) begin
            n_fail++;
            $display("FAIL ar_restart j=%0d: out=%b ov=%b i1=%0d, expected %b %b %0d",
                     j, bus.out, bus.out_valid, dut.i1_q, e.out, e.ov, e.i1);
         end
         if (j >= 1) begin
            n_tests++;
            if (bus.out !== sym_ref[j-1]) begin
               n_fail++;
               $display("FAIL ar_symbol j=%0d: out=%b, expected %b", j, bus.out, sym_ref[j-1]);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_zero_start();
      test_dc(16384, 1024, 760, 776, "dc_pos");
      test_dc(-32768, 4096, 0, 40, "dc_neg");
      test_handshake();
      test_underrun();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dsm_mod2.md
Name: dsm_mod2

Overview:
- Second-order digital delta-sigma modulator. It converts multi-bit PCM samples into the 2-bit signed ±1 bitstream that the CIC/HBF1/HBF2 decimation chain consumes.
- Each accepted input sample is held for OSR modulator clocks (zero-order-hold interpolation).
- One output symbol is produced per clock.
- Used as the on-chip stimulus source for the decimation chain and for loopback tests, replacing the file-based bitstream.

Parameters:
- IN_W, 16, input sample width (signed two's complement); full scale FS = 2^(IN_W-1).
- ACC_W, 20, integrator width (signed); must be ≥ IN_W+2.
- OSR, 64, modulator clocks per input sample; must be ≥ 2.

Ports:
- clk  in  1  system clock (256 MHz nominal).
- rst  in  1  asynchronous, active-low reset.
- in  in  IN_W  signed PCM sample.
- in_valid  in  1  producer has a sample on in.
- in_ready  out  1  block accepts in this cycle.
- out  out  2  signed bitstream symbol: 2'b01 = +1, 2'b11 = -1, 2'b00 only when not valid.
- out_valid  out  1  out carries a modulator symbol.
- underrun  out  1  one-cycle pulse: sample boundary reached with no new sample.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, i1=i2=0, x_hold=0, cnt=0, out=2'b00, out_valid=0, underrun=0. in_ready=1 during and after reset (combinational from state).
- accept = in_valid & in_ready.
- IDLE:
  - in_ready=1.
  - On accept: x_hold<=in, cnt<=0, state<=RUN.
  - No modulator update; out, out_valid unchanged (0).
- RUN: in_ready = (cnt==OSR-1). Every clock edge:
  - y = +1 if i2 ≥ 0, else -1. v = y·FS, sign-extended to ACC_W.
  - out<=y encoding; out_valid<=1.
  - i1' = sat(i1 + ((x_hold - v) >>> 1)).
  - i2' = sat(i2 + ((i1' - v) >>> 1)). i2 uses the newly computed i1'.
  - `>>>` is an arithmetic right shift (floor toward -inf).
  - sat() clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap-around ever.
  - Intermediate sums are computed at ACC_W+2 bits before clamping.
  - cnt<=cnt+1 when cnt<OSR-1.
  - At cnt==OSR-1, cnt<=0, and:
    - If accept: x_hold<=in. The update in this same cycle still uses the old x_hold, so each sample drives exactly OSR updates.
    - If no accept: x_hold unchanged (old sample repeated), underrun<=1 for exactly one cycle.
- underrun is 0 in all other cycles.
- in is ignored when in_ready=0; in_valid may be held high with no effect.
- Latency:
  - First accept in IDLE at edge k → first out_valid=1 at edge k+1.
  - That first symbol is +1 (i2=0).
  - A sample accepted at boundary edge k influences i1 from edge k+1.
- RUN never returns to IDLE except via reset. The bitstream runs continuously once started, matching the chain's one-symbol-per-clock input.
- Reset asserted mid-RUN: all state clears immediately; out=2'b00, out_valid=0 in the same cycle. The block restarts from IDLE after release; no partial sample is retained.
- Simultaneous accept and underrun cannot occur; accept suppresses underrun.
- Stable input range: |in| ≤ 0.75·FS. Larger inputs are legal; saturation keeps state bounded, and output tends to all ±1.

Test Plan:
- Reset, then one sample in=0 with in_valid=1 for one cycle → out_valid rises one edge after accept. First symbols: +1, -1, -1, +1. Check i1 = -16384, 0, +16384 after the first three updates. Underrun pulses at cycle OSR after accept, then every OSR cycles.
- DC in=+16384 (0.5·FS), continuous in_valid → count of +1 over 1024 symbols in 768±8. Feed the stream through cic/hbf1/hbf2 → settled hbf2_out mean within 0.5% of the expected 0.5·FS-scaled value.
- DC in=-32768 sustained for 4096 symbols → no integrator wrap: i1 and i2 stay within the ACC_W range, clamp at the limit when driven. At least 99% of symbols are -1.
- Handshake: in_valid held high with samples 0,1,2,… → in_ready high exactly one cycle in every OSR. Samples are accepted in order, no sample is skipped, and underrun stays 0 for 10 periods.
- Underrun: deassert in_valid after 3 samples → underrun pulses at each subsequent boundary. x_hold keeps the third sample, and the out stream keeps running (out_valid stays 1).
- Async reset: pull rst low mid-period between clock edges → out=2'b00, out_valid=0, in_ready=1 before the next edge. After release, a new sample reproduces the reset-start sequence +1, -1, -1 for in=0.
